ram_arbiter: RTL and testbench

Round-robin arbiter that shares one `simpleDualPortRam` instance among `CLIENTS` requesters. Write and read ports are arbitrated independently, one grant per port per cycle, with fair rotation. Read data returns one cycle after grant, tagged by a one-hot valid. A same-cycle read/write to the same address is resolved by forwarding the write data. Sits between multiple producer/consumer blocks and a shared block-RAM buffer.

---
 rtl/ram_arbiter_pkg.sv | 31 +++
 rtl/ram_arbiter_if.sv | 27 ++
 rtl/ram_arbiter_rr_arbiter.sv | 45 ++++
 rtl/simple_dual_port_ram.sv | 24 ++
 rtl/ram_arbiter.sv | 77 +++++++
 tb/tb_ram_arbiter.sv | 187 ++++++++++++++++++
 6 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared constants and helpers for the round-robin RAM arbiter.
// Width helpers let parameterised modules derive AW/CW from their own parameters.
package ram_arbiter_pkg;

  localparam int MAX_CLIENTS = 8;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_ENTRIES = 256;
  localparam int DEF_CLIENTS = 2;

  function automatic int addr_width(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AW = addr_width(DEF_ENTRIES);
  localparam int CW = idx_width(DEF_CLIENTS);

  // OR-combines bit positions, so the result is only meaningful for one-hot input.
  function automatic logic [2:0] oh_to_idx(input logic [MAX_CLIENTS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CLIENTS; i++) begin
      idx = idx | (oh[i] ? 3'(i) : 3'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Client-side bus of the RAM arbiter: packed per-client write/read requests and returns.
// valid/ready: a request (wreq/rreq) is a level held with stable address/data until its ack; ack means transferred this cycle.
interface ram_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int AW      = 8,
  parameter int CLIENTS = 2
);
  logic [CLIENTS-1:0]         wreq;
  logic [CLIENTS*AW-1:0]      waddr;
  logic [CLIENTS*WIDTH-1:0]   wdata;
  logic [CLIENTS-1:0]         wack;
  logic [CLIENTS-1:0]         rreq;
  logic [CLIENTS*AW-1:0]      raddr;
  logic [CLIENTS-1:0]         rack;
  logic [CLIENTS-1:0]         rvalid;
  logic [WIDTH-1:0]           rdata;

  modport master (
    output wreq, waddr, wdata, rreq, raddr,
    input  wack, rack, rvalid, rdata
  );

  modport slave (
    input  wreq, waddr, wdata, rreq, raddr,
    output wack, rack, rvalid, rdata
  );
endinterface

// File: rtl/ram_arbiter_rr_arbiter.sv
// Round-robin picker: search starts one past the last winner, first set request wins.
// Grants are forced low while reset is held.
module rr_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int N = 2,
  localparam int NCW = idx_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [NCW-1:0] grant_idx
);
  logic [NCW-1:0]         ptr;
  logic [MAX_CLIENTS-1:0] grant_ext;
  logic                   found;
  int                     j;

  always_comb begin
    grant = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
    if (!rst_n) grant = '0;
  end

  always_comb begin
    grant_ext        = '0;
    grant_ext[N-1:0] = grant;
    grant_idx        = NCW'(oh_to_idx(grant_ext));
  end

  // Reset to N-1 so client 0 is first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= NCW'(N - 1);
    else if (|grant) ptr <= grant_idx;
  end
endmodule

// File: rtl/simple_dual_port_ram.sv
// Block-RAM style memory: one synchronous write port, one registered read port.
// A same-address read and write at one edge returns the old word.
module simpleDualPortRam #(
  parameter int WIDTH = 8,
  parameter int AW    = 8
) (
  input  logic             wclk,
  input  logic             writeEnable,
  input  logic [AW-1:0]    writeAddr,
  input  logic [WIDTH-1:0] writeData,
  input  logic             rclk,
  input  logic [AW-1:0]    readAddr,
  output logic [WIDTH-1:0] readData
);
  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge wclk) begin
    if (writeEnable) mem[writeAddr] <= writeData;
  end

  always_ff @(posedge rclk) begin
    readData <= mem[readAddr];
  end
endmodule

// File: rtl/ram_arbiter.sv
// Shares one simple dual-port RAM among CLIENTS requesters with independent
// round-robin write and read arbitration and same-cycle write-to-read forwarding.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int CLIENTS = DEF_CLIENTS
) (
  input logic          clk,
  input logic          rst_n,
  ram_arbiter_if.slave bus
);
  localparam int LAW = addr_width(ENTRIES);
  localparam int LCW = idx_width(CLIENTS);

  logic [LCW-1:0]     w_idx, r_idx;
  logic [LAW-1:0]     w_addr_sel, r_addr_sel;
  logic [WIDTH-1:0]   w_data_sel;
  logic [WIDTH-1:0]   ram_rdata;
  logic               collision;
  logic [CLIENTS-1:0] rv_q;
  logic               fwd_q;
  logic [WIDTH-1:0]   fwd_data_q;

  rr_arbiter #(.N(CLIENTS)) u_warb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.wreq),
    .grant     (bus.wack),
    .grant_idx (w_idx)
  );

  rr_arbiter #(.N(CLIENTS)) u_rarb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.rreq),
    .grant     (bus.rack),
    .grant_idx (r_idx)
  );

  assign w_addr_sel = bus.waddr[int'(w_idx)*LAW +: LAW];
  assign w_data_sel = bus.wdata[int'(w_idx)*WIDTH +: WIDTH];
  assign r_addr_sel = bus.raddr[int'(r_idx)*LAW +: LAW];

  // The RAM returns the old word on a same-address collision, so the new one is bypassed.
  assign collision = (|bus.wack) && (|bus.rack) && (w_addr_sel == r_addr_sel);

  simpleDualPortRam #(.WIDTH(WIDTH), .AW(LAW)) u_ram (
    .wclk        (clk),
    .writeEnable (|bus.wack),
    .writeAddr   (w_addr_sel),
    .writeData   (w_data_sel),
    .rclk        (clk),
    .readAddr    (r_addr_sel),
    .readData    (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q       <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      rv_q  <= bus.rack;
      fwd_q <= collision;
      if (collision) fwd_data_q <= w_data_sel;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (|rv_q) bus.rdata = fwd_q ? fwd_data_q : ram_rdata;
  end

  assign bus.rvalid = rv_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a 2-client instance for the main behaviour and
// a 4-client instance for rotation fairness.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt [4];

  always #5 clk = ~clk;

  ram_arbiter_if #(.WIDTH(8), .AW(8), .CLIENTS(2)) a_if ();
  ram_arbiter_if #(.WIDTH(8), .AW(8), .CLIENTS(4)) b_if ();

  ram_arbiter #(.WIDTH(8), .ENTRIES(256), .CLIENTS(2)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (a_if.slave)
  );
  ram_arbiter #(.WIDTH(8), .ENTRIES(256), .CLIENTS(4)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (b_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int c, input logic [7:0] addr, input logic [7:0] data);
    a_if.waddr[c*8 +: 8] = addr;
    a_if.wdata[c*8 +: 8] = data;
  endtask

  task automatic set_r(input int c, input logic [7:0] addr);
    a_if.raddr[c*8 +: 8] = addr;
  endtask

  initial begin
    rst_n      = 1'b0;
    a_if.wreq  = 2'b11;
    a_if.rreq  = 2'b11;
    a_if.waddr = '0;
    a_if.wdata = '0;
    a_if.raddr = '0;
    b_if.wreq  = '0;
    b_if.rreq  = 4'b1111;
    b_if.waddr = '0;
    b_if.wdata = '0;
    b_if.raddr = {8'd30, 8'd20, 8'd10, 8'd0};
    foreach (cnt[i]) cnt[i] = 0;

    // Reset with all requests high: everything gated.
    tick();
    tick();
    check("rst_wack", a_if.wack, 2'b00);
    check("rst_rack", a_if.rack, 2'b00);
    check("rst_rvalid", a_if.rvalid, 2'b00);
    check("rst_rdata", a_if.rdata, 8'h00);
    check("rst_b_rack", b_if.rack, 4'b0000);
    check("rst_b_rvalid", b_if.rvalid, 4'b0000);

    // Release; both clients write continuously for four cycles.
    a_if.rreq = 2'b00;
    b_if.rreq = 4'b0000;
    set_w(0, 8'd3, 8'hA5);
    set_w(1, 8'd4, 8'h5A);
    a_if.wreq = 2'b11;
    rst_n     = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("wack_rr", a_if.wack, (k % 2 == 1) ? 2'b10 : 2'b01);
      tick();
    end

    // Single reads with one-cycle latency and tagging.
    a_if.wreq = 2'b00;
    set_r(0, 8'd3);
    a_if.rreq = 2'b01;
    #1;
    check("rd0_rack", a_if.rack, 2'b01);
    tick();
    check("rd0_rvalid", a_if.rvalid, 2'b01);
    check("rd0_rdata", a_if.rdata, 8'hA5);
    set_r(1, 8'd4);
    a_if.rreq = 2'b10;
    #1;
    check("rd1_rack", a_if.rack, 2'b10);
    tick();
    check("rd1_rvalid", a_if.rvalid, 2'b10);
    check("rd1_rdata", a_if.rdata, 8'h5A);
    a_if.rreq = 2'b00;
    #1;
    check("idle_rack", a_if.rack, 2'b00);
    tick();
    check("idle_rvalid", a_if.rvalid, 2'b00);
    check("idle_rdata", a_if.rdata, 8'h00);

    // Back-to-back reads from both clients.
    a_if.rreq = 2'b11;
    #1;
    check("b2b_rack0", a_if.rack, 2'b01);
    tick();
    check("b2b_rvalid0", a_if.rvalid, 2'b01);
    check("b2b_rdata0", a_if.rdata, 8'hA5);
    #1;
    check("b2b_rack1", a_if.rack, 2'b10);
    tick();
    a_if.rreq = 2'b00;
    check("b2b_rvalid1", a_if.rvalid, 2'b10);
    check("b2b_rdata1", a_if.rdata, 8'h5A);

    // Collision: address 7 holds 0x11, then write 0x22 and read it in the same cycle.
    set_w(0, 8'd7, 8'h11);
    a_if.wreq = 2'b01;
    #1;
    check("col_pre_wack", a_if.wack, 2'b01);
    tick();
    set_w(0, 8'd7, 8'h22);
    set_r(1, 8'd7);
    a_if.rreq = 2'b10;
    #1;
    check("col_wack", a_if.wack, 2'b01);
    check("col_rack", a_if.rack, 2'b10);
    tick();
    a_if.wreq = 2'b00;
    a_if.rreq = 2'b00;
    check("col_rvalid", a_if.rvalid, 2'b10);
    check("col_rdata", a_if.rdata, 8'h22);
    set_r(0, 8'd7);
    a_if.rreq = 2'b01;
    #1;
    check("col_reread_rack", a_if.rack, 2'b01);
    tick();
    a_if.rreq = 2'b00;
    check("col_reread_rdata", a_if.rdata, 8'h22);

    // Reset asserted while a read is being granted: no rvalid ever appears.
    set_r(0, 8'd3);
    a_if.rreq = 2'b01;
    #1;
    check("mid_rack", a_if.rack, 2'b01);
    rst_n = 1'b0;
    #1;
    check("mid_rack_gated", a_if.rack, 2'b00);
    tick();
    check("mid_rvalid", a_if.rvalid, 2'b00);
    check("mid_rdata", a_if.rdata, 8'h00);
    tick();
    set_w(0, 8'd7, 8'h22);
    set_r(1, 8'd7);
    a_if.wreq = 2'b11;
    a_if.rreq = 2'b11;
    rst_n     = 1'b1;
    #1;
    check("post_rst_wack", a_if.wack, 2'b01);
    check("post_rst_rack", a_if.rack, 2'b01);
    tick();
    a_if.wreq = 2'b00;
    a_if.rreq = 2'b00;
    check("post_rst_rvalid", a_if.rvalid, 2'b01);
    check("post_rst_rdata", a_if.rdata, 8'hA5);

    // Four clients all reading for eight cycles: strict rotation.
    b_if.rreq = 4'b1111;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("b_rack_order", b_if.rack, 4'b0001 << (k % 4));
      tick();
      if (k == 7) b_if.rreq = 4'b0000;
      check("b_rvalid_tag", b_if.rvalid, 4'b0001 << (k % 4));
      for (int c = 0; c < 4; c++) cnt[c] += int'(b_if.rvalid[c]);
      #1;
    end
    tick();
    check("b_rvalid_end", b_if.rvalid, 4'b0000);
    for (int c = 0; c < 4; c++) check("b_pulse_count", cnt[c], 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
